control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired multi-cycle control unit for the bus-based datapath. Walks a T0–T6 step counter, decodes the opcode held in the datapath IR, and drives every bus-drive, register-load and ALU-select strobe the datapath consumes. It is the stage directly upstream of the datapath: it replaces the hand-driven strobes of the datapath benches, and its outputs connect one-to-one to the datapath's control inputs.

## Interface
- Parameters: none; opcodes and state codes come from the shared package.
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high; forces state T0, all outputs 0
- ir  in  32  datapath IR contents; opcode = ir[31:27]; ra/rb/rc fields are decoded by the datapath select-encode logic
- mem_ready  in  1  memory read data valid this cycle
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout  out  1 each  bus drive strobes
- MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin  out  1 each  register load strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  general-register select and load/drive
- IncPC, Read  out  1 each  PC increment; memory read request
- alu_op  out  5  ALU operation; equals ir[31:27] when Zin is asserted in T3/T4, else 0
- run  out  1  1 while fetching/executing; 0 in HALT and during reset

## Operation
- States: T0..T6, HALT. Outputs are combinational from state, ir and mem_ready. A strobe is 0 unless listed below.
- T0: PCout, MARin, IncPC, Zin. Next state: T1.
- T1: Read held 1. While mem_ready=0, no other strobe is asserted and the state stays T1. When mem_ready=1, assert Zlowout, PCin and MDRin; next state T2.
- T2: MDRout, IRin. Next state: T3. ir is valid from T3 onward.
- R-type ALU ops (add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op.
  - T5: Zlowout, Gra, Rin; then T0.
- mul 01111, div 10000:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, Zin, alu_op.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; then T0.
- neg 10001, not 10010:
  - T3: Grb, Rout, Zin, alu_op.
  - T4: Zlowout, Gra, Rin; then T0.
- mfhi 11000: T3: HIout, Gra, Rin; then T0. mflo 11001: T3: LOout, Gra, Rin; then T0.
- nop 11010, and any opcode not listed above: T3 asserts nothing; then T0.
- halt 11011: T3 asserts nothing; next state HALT. HALT asserts nothing, sets run=0, and is left only by reset.

## Timing
- Reset: while reset=1, all outputs are 0, run is 0, and the state is T0 after the edge. In the first cycle after reset deasserts, T0 strobes are driven and run=1.
- Instruction length, with a zero-wait memory (mem_ready=1 in the first T1 cycle):
  - nop, mfhi, mflo: 4 cycles
  - neg, not: 5 cycles
  - R-type ALU ops: 6 cycles
  - mul, div: 7 cycles
- Each cycle with mem_ready=0 in T1 adds one cycle.
- Handshake: Read rises on T1 entry and stays high until the cycle mem_ready=1, inclusive. MDRin and PCin pulse exactly once per fetch.
- Reset asserted in any state, including a T1 stall or HALT, returns to T0 on the next edge with no partial strobes.
- A mem_ready pulse outside T1 is ignored.
- At most one bus drive strobe is high in any cycle. Checked by bench assertion.

## Structure
- Package cpu_ctrl_pkg holds:
  - the 5-bit opcode localparams listed above
  - the 4-bit state codes: T0..T6 = 0..6, HALT = 7
  - the instruction-class enum: ALU3, MULDIV, UNARY, MOVHL, NOP, HALT
- Sub-module opcode_classifier: combinational, maps opcode to class. It is shared by the sequencer and by later decode stages.
- The sequencer module holds the state register and the per-state output decode.

## Test plan
- Reset, then IR = 32'h28918000 (and R1,R2,R3), mem_ready tied 1 -> T0..T5 in 6 cycles:
  - T4: alu_op = 5'b00101
  - T5: Zlowout, Gra, Rin; then T0.
- mem_ready held 0 for 3 cycles in T1 -> Read high for 4 cycles; PCin/MDRin pulse once, in cycle 4; T2 follows.
- IR opcode 01111 (mul) -> T5 asserts LOin with Zlowout; T6 asserts HIin with Zhighout; 7-cycle instruction.
- IR opcode 11000 (mfhi), then 11010 (nop), then opcode 11111 (unlisted) -> 4 cycles each.
  - mfhi asserts HIout, Gra, Rin in T3.
  - nop and opcode 11111 assert no T3 strobes.
- IR opcode 11011 (halt) -> run drops after T3; 20 cycles of all-zero outputs; reset -> T0 strobes next cycle.
- Reset pulsed during a T4 of add -> next cycle all outputs 0; the following cycle shows T0 strobes; no Rin is issued.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, sequencer
// states, instruction classes and the control-strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_HALT = 4'd7
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_MOVHL,
        CLS_NOP,
        CLS_HALT
    } instr_class_t;

    typedef struct packed {
        logic       pc_out;
        logic       zlow_out;
        logic       zhigh_out;
        logic       mdr_out;
        logic       hi_out;
        logic       lo_out;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       hi_in;
        logic       lo_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       inc_pc;
        logic       read;
        logic [4:0] alu_op;
        logic       run;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic [4:0] opcode_of(input logic [31:0] ir);
        return ir[31:27];
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps a 5-bit opcode to its execution class; shared by the sequencer and
// later decode stages.
module opcode_classifier
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t iclass
);

    always_comb begin
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: iclass = CLS_ALU3;
            OP_MUL, OP_DIV:                  iclass = CLS_MULDIV;
            OP_NEG, OP_NOT:                  iclass = CLS_UNARY;
            OP_MFHI, OP_MFLO:                iclass = CLS_MOVHL;
            OP_HALT:                         iclass = CLS_HALT;
            default:                         iclass = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T0-T6 control unit: fetches, decodes the IR opcode and drives
// every datapath strobe combinationally from step, opcode and mem_ready.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic [4:0]  alu_op,
    output logic        run
);

    state_t       state;
    state_t       next_state;
    ctrl_t        ctrl;
    instr_class_t iclass;
    logic [4:0]   opcode;

    // Register fields are decoded by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^ir[26:0];

    assign opcode = opcode_of(ir);

    opcode_classifier u_classifier (
        .opcode (opcode),
        .iclass (iclass)
    );

    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_T0;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output and next_state get a default before the case so
        // no path leaves them unassigned and no latch is inferred.
        ctrl       = CTRL_IDLE;
        next_state = state;
        case (state)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.z_in   = 1'b1;
                next_state  = ST_T1;
            end
            ST_T1: begin
                ctrl.read = 1'b1;
                if (mem_ready) begin
                    ctrl.zlow_out = 1'b1;
                    ctrl.pc_in    = 1'b1;
                    ctrl.mdr_in   = 1'b1;
                    next_state    = ST_T2;
                end
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                next_state   = ST_T3;
            end
            ST_T3: begin
                next_state = ST_T0;
                case (iclass)
                    CLS_ALU3: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                        next_state = ST_T4;
                    end
                    CLS_MULDIV: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                        next_state = ST_T4;
                    end
                    CLS_UNARY: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                        next_state  = ST_T4;
                    end
                    CLS_MOVHL: begin
                        ctrl.hi_out = (opcode == OP_MFHI);
                        ctrl.lo_out = (opcode != OP_MFHI);
                        ctrl.gra    = 1'b1;
                        ctrl.r_in   = 1'b1;
                    end
                    CLS_HALT: next_state = ST_HALT;
                    default:  next_state = ST_T0;
                endcase
            end
            ST_T4: begin
                next_state = ST_T0;
                case (iclass)
                    CLS_ALU3: begin
                        ctrl.grc    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                        next_state  = ST_T5;
                    end
                    CLS_MULDIV: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = opcode;
                        next_state  = ST_T5;
                    end
                    CLS_UNARY: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    default: next_state = ST_T0;
                endcase
            end
            ST_T5: begin
                next_state = ST_T0;
                case (iclass)
                    CLS_ALU3: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.lo_in    = 1'b1;
                        next_state    = ST_T6;
                    end
                    default: next_state = ST_T0;
                endcase
            end
            ST_T6: begin
                ctrl.zhigh_out = 1'b1;
                ctrl.hi_in     = 1'b1;
                next_state     = ST_T0;
            end
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_T0;
        endcase

        ctrl.run = (state != ST_HALT);
        // Reset is synchronous, so outputs are squashed here to keep the
        // reset cycle free of partial strobes from whatever state we were in.
        if (reset) ctrl = CTRL_IDLE;
    end

    assign PCout    = ctrl.pc_out;
    assign Zlowout  = ctrl.zlow_out;
    assign Zhighout = ctrl.zhigh_out;
    assign MDRout   = ctrl.mdr_out;
    assign HIout    = ctrl.hi_out;
    assign LOout    = ctrl.lo_out;
    assign MARin    = ctrl.mar_in;
    assign PCin     = ctrl.pc_in;
    assign MDRin    = ctrl.mdr_in;
    assign IRin     = ctrl.ir_in;
    assign Yin      = ctrl.y_in;
    assign Zin      = ctrl.z_in;
    assign HIin     = ctrl.hi_in;
    assign LOin     = ctrl.lo_in;
    assign Gra      = ctrl.gra;
    assign Grb      = ctrl.grb;
    assign Grc      = ctrl.grc;
    assign Rin      = ctrl.r_in;
    assign Rout     = ctrl.r_out;
    assign IncPC    = ctrl.inc_pc;
    assign Read     = ctrl.read;
    assign alu_op   = ctrl.alu_op;
    assign run      = ctrl.run;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a per-instruction micro-step
// plan model feeds an expected-output queue checked every cycle.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = '0;
    logic        mem_ready = 1'b0;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
    logic MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, run;
    logic [4:0] alu_op;

    control_sequencer dut (
        .clock(clock), .reset(reset), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .alu_op(alu_op), .run(run)
    );

    always #5 clock = ~clock;

    // Output vector layout, bit 0 upward.
    localparam logic [31:0] PCOUT    = 32'h1 << 0;
    localparam logic [31:0] ZLOWOUT  = 32'h1 << 1;
    localparam logic [31:0] ZHIGHOUT = 32'h1 << 2;
    localparam logic [31:0] MDROUT   = 32'h1 << 3;
    localparam logic [31:0] HIOUT    = 32'h1 << 4;
    localparam logic [31:0] LOOUT    = 32'h1 << 5;
    localparam logic [31:0] MARIN    = 32'h1 << 6;
    localparam logic [31:0] PCIN     = 32'h1 << 7;
    localparam logic [31:0] MDRIN    = 32'h1 << 8;
    localparam logic [31:0] IRIN     = 32'h1 << 9;
    localparam logic [31:0] YIN      = 32'h1 << 10;
    localparam logic [31:0] ZIN      = 32'h1 << 11;
    localparam logic [31:0] HIIN     = 32'h1 << 12;
    localparam logic [31:0] LOIN     = 32'h1 << 13;
    localparam logic [31:0] GRA      = 32'h1 << 14;
    localparam logic [31:0] GRB      = 32'h1 << 15;
    localparam logic [31:0] GRC      = 32'h1 << 16;
    localparam logic [31:0] RIN      = 32'h1 << 17;
    localparam logic [31:0] ROUT     = 32'h1 << 18;
    localparam logic [31:0] INCPC    = 32'h1 << 19;
    localparam logic [31:0] READ     = 32'h1 << 20;
    localparam logic [31:0] RUN      = 32'h1 << 21;

    logic [31:0] dut_vec;
    assign dut_vec = {5'b0, alu_op, run, Read, IncPC, Rout, Rin, Grc, Grb, Gra,
                      LOin, HIin, Zin, Yin, IRin, MDRin, PCin, MARin,
                      LOout, HIout, MDRout, Zhighout, Zlowout, PCout};

    typedef struct {
        logic [31:0] exp;
        logic        mr;
        logic        rst;
        logic [31:0] irv;
    } vec_t;

    vec_t        plan_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] dut_log[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] alu(input logic [4:0] op);
        return {5'b0, op, 22'b0};
    endfunction

    task automatic push(input logic [31:0] e, input logic mr, input logic rst,
                        input logic [31:0] irv);
        vec_t v;
        v.exp = e; v.mr = mr; v.rst = rst; v.irv = irv;
        plan_q.push_back(v);
    endtask

    // Model: the micro-step program of one instruction, written from the
    // fetch/execute rules. mem_ready toggles outside T1 to show it is ignored.
    task automatic gen(input logic [4:0] op, input int stalls);
        logic [31:0] irv;
        logic [31:0] ex[$];
        irv = {op, 27'h0918000};
        push(RUN | PCOUT | MARIN | INCPC | ZIN, 1'b1, 1'b0, irv);
        for (int i = 0; i < stalls; i++) push(RUN | READ, 1'b0, 1'b0, irv);
        push(RUN | READ | ZLOWOUT | PCIN | MDRIN, 1'b1, 1'b0, irv);
        push(RUN | MDROUT | IRIN, 1'b1, 1'b0, irv);
        if (op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                       5'b01000, 5'b01001, 5'b01010, 5'b01011}) begin
            ex.push_back(RUN | GRB | ROUT | YIN);
            ex.push_back(RUN | GRC | ROUT | ZIN | alu(op));
            ex.push_back(RUN | ZLOWOUT | GRA | RIN);
        end else if (op inside {5'b01111, 5'b10000}) begin
            ex.push_back(RUN | GRA | ROUT | YIN);
            ex.push_back(RUN | GRB | ROUT | ZIN | alu(op));
            ex.push_back(RUN | ZLOWOUT | LOIN);
            ex.push_back(RUN | ZHIGHOUT | HIIN);
        end else if (op inside {5'b10001, 5'b10010}) begin
            ex.push_back(RUN | GRB | ROUT | ZIN | alu(op));
            ex.push_back(RUN | ZLOWOUT | GRA | RIN);
        end else if (op == 5'b11000) begin
            ex.push_back(RUN | HIOUT | GRA | RIN);
        end else if (op == 5'b11001) begin
            ex.push_back(RUN | LOOUT | GRA | RIN);
        end else begin
            ex.push_back(RUN);
        end
        for (int i = 0; i < ex.size(); i++) push(ex[i], logic'(i % 2), 1'b0, irv);
    endtask

    task automatic play();
        vec_t v;
        while (plan_q.size() > 0) begin
            v = plan_q.pop_front();
            @(posedge clock);
            #1;
            ir = v.irv;
            mem_ready = v.mr;
            reset = v.rst;
            exp_q.push_back(v.exp);
        end
        @(negedge clock);
        #1;
    endtask

    function automatic int count_bit(input logic [31:0] mask);
        int n = 0;
        foreach (dut_log[i]) if ((dut_log[i] & mask) != 0) n++;
        return n;
    endfunction

    // Compare process: every driven cycle is checked away from the edge.
    always @(negedge clock) begin
        cyc++;
        if (exp_q.size() != 0) begin
            check("outputs", dut_vec, exp_q.pop_front());
            dut_log.push_back(dut_vec);
            vectors++;
            assert ($onehot0({PCout, Zlowout, Zhighout, MDRout, HIout, LOout}))
            else begin
                miscompares++;
                $display("FAIL bus_drive cycle %0d: drives %b expected at most one",
                         cyc, {PCout, Zlowout, Zhighout, MDRout, HIout, LOout});
            end
        end
    end

    initial begin
        // Reset.
        push(32'h0, 1'b0, 1'b1, 32'h0);
        push(32'h0, 1'b1, 1'b1, 32'h0);
        play();
        check("reset_outputs", dut_log[1], 32'h0);

        // and R1,R2,R3 with zero-wait memory.
        dut_log.delete();
        for (int i = 0; i < 6; i++) push(32'h0, 1'b1, 1'b0, 32'h28918000);
        plan_q.delete();
        gen(5'b00101, 0);
        play();
        check("and_length", dut_log.size(), 6);
        check("and_t0", dut_log[0], 32'h00280841);
        check("and_t4_aluop", {27'b0, dut_log[4][26:22]}, 32'h5);
        check("and_t5", dut_log[5], 32'h00224002);

        // Fetch with three wait cycles.
        dut_log.delete();
        gen(5'b00100, 3);
        play();
        check("stall_read_cycles", count_bit(READ), 4);
        check("stall_pcin_pulses", count_bit(PCIN), 1);
        check("stall_mdrin_pulses", count_bit(MDRIN), 1);
        check("stall_pcin_cycle4", {31'b0, dut_log[4][7]}, 32'h1);
        check("stall_t2_irin", {31'b0, dut_log[5][9]}, 32'h1);
        check("stall_length", dut_log.size(), 9);

        // mul.
        dut_log.delete();
        gen(5'b01111, 0);
        play();
        check("mul_length", dut_log.size(), 7);
        check("mul_t5", dut_log[5], 32'h00202002);
        check("mul_t6", dut_log[6], 32'h00201004);

        // mfhi, nop, unlisted 11111.
        dut_log.delete();
        gen(5'b11000, 0);
        play();
        check("mfhi_length", dut_log.size(), 4);
        check("mfhi_t3", dut_log[3], 32'h00224010);
        dut_log.delete();
        gen(5'b11010, 0);
        play();
        check("nop_length", dut_log.size(), 4);
        check("nop_t3", dut_log[3], 32'h00200000);
        dut_log.delete();
        gen(5'b11111, 0);
        play();
        check("op11111_length", dut_log.size(), 4);
        check("op11111_t3", dut_log[3], 32'h00200000);

        // Remaining classes with assorted stalls, model-checked each cycle.
        gen(5'b01000, 1);
        gen(5'b10000, 2);
        gen(5'b10001, 0);
        gen(5'b10010, 1);
        gen(5'b11001, 0);
        gen(5'b01100, 2);
        gen(5'b01011, 0);
        play();

        // halt, 20 idle cycles, then reset.
        dut_log.delete();
        gen(5'b11011, 0);
        for (int i = 0; i < 20; i++) push(32'h0, logic'(i % 2), 1'b0, 32'hD8000000);
        push(32'h0, 1'b1, 1'b1, 32'hD8000000);
        gen(5'b11010, 0);
        play();
        check("halt_run_cycles", count_bit(RUN), 4 + 4);
        check("halt_after_reset_t0", dut_log[25], 32'h00280841);

        // Reset during T4 of add.
        dut_log.delete();
        gen(5'b00011, 0);
        while (plan_q.size() > 4) void'(plan_q.pop_back());
        push(32'h0, 1'b1, 1'b1, 32'h18918000);
        gen(5'b11010, 0);
        play();
        check("abort_reset_cycle", dut_log[4], 32'h0);
        check("abort_then_t0", dut_log[5], 32'h00280841);
        check("abort_no_rin", count_bit(RIN), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
